uart_transmitter: RTL and testbench



---
 rtl/uart_transmitter.sv | 181 ++++++++++++++++++
 tb/tb_uart_transmitter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// Buffered UART transmitter: valid/ready byte intake, circular FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_transmitter #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic [7:0]                    data,
  input  logic                          valid,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  state_t        state, state_nx;
  logic [CW-1:0] baud_cnt, baud_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    shift, shift_nx;
  logic          tx_nx;
  logic          push, pop;
  logic          baud_done;

`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  assign ready     = (count != FULL_CNT);
  assign push      = valid && ready;
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign busy      = (state != S_IDLE) || (count != '0);
  assign fill      = count;

  // NOTE: storage has no reset; pointers and count define validity, so stale
  // contents are never read and the array maps onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt + 1'b1;
    bit_nx   = bit_idx;
    shift_nx = shift;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        baud_nx = '0;
        if (count != '0) begin
          pop      = 1'b1;
          shift_nx = mem[rd_ptr];
          state_nx = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_nx  = '0;
          bit_nx   = 3'd0;
          state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_nx  = '0;
          shift_nx = {1'b0, shift[7:1]};
          bit_nx   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nx = S_PARITY;
`else
            state_nx = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_done) begin
          baud_nx  = '0;
          state_nx = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_done) begin
          baud_nx = '0;
          // Chain straight into the next start bit when more data is queued.
          if (count != '0) begin
            pop      = 1'b1;
            shift_nx = mem[rd_ptr];
            state_nx = S_START;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: begin
        baud_nx  = '0;
        state_nx = S_IDLE;
      end
    endcase

    // The line level is decoded from the next state so tx is a clean flop output.
    case (state_nx)
      S_START:  tx_nx = 1'b0;
      S_DATA:   tx_nx = shift_nx[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_nx = parity_q;
`endif
      default:  tx_nx = 1'b1;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_idx  <= bit_nx;
      shift    <= shift_nx;
      tx       <= tx_nx;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)    parity_q <= 1'b0;
    else if (pop) parity_q <= ^mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter (small DIV=10 instance plus a
// default-parameter instance); honours UART_TX_PARITY_EN for 8E1 expectations.
module tb_uart_transmitter;

  localparam int DIV  = 10;
  localparam int DDIV = 434;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
  localparam logic [10:0] A5_FRAME = 11'h54A;
  localparam logic [10:0] MASK     = 11'h7FF;
`else
  localparam int FB = 10;
  localparam logic [10:0] A5_FRAME = 11'h34A;
  localparam logic [10:0] MASK     = 11'h3FF;
`endif
  localparam int FL = FB * DIV;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic [7:0] data = '0;
  logic       valid = 1'b0;
  logic       ready, tx, busy;
  logic [3:0] fill;

  logic [7:0] d_data = '0;
  logic       d_valid = 1'b0;
  logic       d_ready, d_tx, d_busy;
  logic [3:0] d_fill;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_(rst_), .data(data), .valid(valid),
    .ready(ready), .tx(tx), .busy(busy), .fill(fill)
  );

  uart_transmitter dut_d (
    .clk(clk), .rst_(rst_), .data(d_data), .valid(d_valid),
    .ready(d_ready), .tx(d_tx), .busy(d_busy), .fill(d_fill)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for frame bit position idx of byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic wait_fall(input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_fall"}, 32'(tx), 32'd0);
  endtask

  // Called on the first negedge with tx low; checks every cycle of one frame.
  task automatic frame_check(input string tag, input logic [7:0] b, output logic [10:0] mid);
    int errs = 0;
    mid = '1;
    for (int k = 0; k < FL; k++) begin
      if (k > 0) @(negedge clk);
      if (tx !== exp_bit(b, k / DIV)) errs++;
      if (k % DIV == DIV / 2) mid[k / DIV] = tx;
    end
    check({tag, "_wave"}, 32'(errs), 32'd0);
    check({tag, "_busy_last"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_tx_end"}, 32'(tx), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] mid;
    logic [7:0]  b;
    int          errs;
    int          n;
    int          tot;

    // 1: reset values, latency and a single 0xA5 frame
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd1);
    check("rst_d_fill", 32'(d_fill), 32'd0);
    rst_ = 1'b1;
    @(negedge clk);
    valid = 1'b1; data = 8'hA5;
    @(negedge clk);
    valid = 1'b0;
    check("t1_fill_push", 32'(fill), 32'd1);
    check("t1_tx_push", 32'(tx), 32'd1);
    check("t1_busy_push", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_fill_pop", 32'(fill), 32'd0);
    check("t1_start", 32'(tx), 32'd0);
    frame_check("t1", 8'hA5, mid);
    check("t1_bits", 32'(mid & MASK), 32'(A5_FRAME));

    // 2+3: fill to full behind a running frame, drop a 9th valid, push during a pop
    @(negedge clk);
    valid = 1'b1; data = 8'hF0;
    @(negedge clk);
    valid = 1'b0;
    check("t2_fill_f0", 32'(fill), 32'd1);
    @(negedge clk);
    wait_fall("t2");
    errs = 0;
    for (int k = 0; k < 10 * FL; k++) begin
      if (k > 0) @(negedge clk);
      b = (k / FL == 0) ? 8'hF0 : 8'(k / FL - 1);
      if (tx !== exp_bit(b, (k % FL) / DIV)) errs++;
      if (k == 8 || k == FL - 1) begin
        check("t2_full_fill", 32'(fill), 32'd8);
        check("t2_full_ready", 32'(ready), 32'd0);
      end
      if (k == FL) begin
        check("t2_pop_fill", 32'(fill), 32'd7);
        check("t2_pop_ready", 32'(ready), 32'd1);
      end
      if (k == 2 * FL - 1) check("t3_ready_pre", 32'(ready), 32'd1);
      if (k == 2 * FL - 1 || k == 2 * FL) check("t3_fill", 32'(fill), 32'd7);
      if (k == 10 * FL - 1) check("t2_busy_last", 32'(busy), 32'd1);
      if (k < 8) begin
        valid = 1'b1; data = 8'(k);
      end else if (k < FL) begin
        valid = 1'b1; data = 8'hEE;
      end else if (k == 2 * FL - 1) begin
        valid = 1'b1; data = 8'h08;
      end else begin
        valid = 1'b0;
      end
    end
    check("t2_wave", 32'(errs), 32'd0);
    @(negedge clk);
    check("t2_busy_end", 32'(busy), 32'd0);
    check("t2_fill_end", 32'(fill), 32'd0);

`ifdef UART_TX_PARITY_EN
    // 5: even parity bit
    valid = 1'b1; data = 8'h07;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    wait_fall("t5a");
    frame_check("t5a", 8'h07, mid);
    check("t5_par07", 32'(mid[9]), 32'd1);
    valid = 1'b1; data = 8'h03;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    wait_fall("t5b");
    frame_check("t5b", 8'h03, mid);
    check("t5_par03", 32'(mid[9]), 32'd0);
`endif

    // 6: default parameters, 0x55
    d_valid = 1'b1; d_data = 8'h55;
    @(negedge clk);
    d_valid = 1'b0;
    n = 0;
    while (d_tx !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t6_fall", 32'(d_tx), 32'd0);
    n = 0;
    while (d_tx === 1'b0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("t6_start_len", 32'(n), 32'(DDIV));
    tot = n;
    while (d_busy === 1'b1 && tot < 6000) begin
      tot++;
      @(negedge clk);
    end
    check("t6_frame_len", 32'(tot), 32'(FB * DDIV));

    // 4: reset mid-frame
    valid = 1'b1; data = 8'hFF;
    @(negedge clk);
    data = 8'h12;
    @(negedge clk);
    data = 8'h34;
    @(negedge clk);
    valid = 1'b0;
    check("t4_fill_pre", 32'(fill), 32'd2);
    repeat (30) @(negedge clk);
    check("t4_busy_pre", 32'(busy), 32'd1);
    #2 rst_ = 1'b0;
    #1;
    check("t4_tx_async", 32'(tx), 32'd1);
    check("t4_fill_async", 32'(fill), 32'd0);
    check("t4_busy_async", 32'(busy), 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    errs = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("t4_quiet", 32'(errs), 32'd0);

    valid = 1'b1; data = 8'h00;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    wait_fall("t4b");
    repeat (3) @(negedge clk);
    check("t4b_tx_low", 32'(tx), 32'd0);
    #2 rst_ = 1'b0;
    #1;
    check("t4b_tx_async", 32'(tx), 32'd1);
    @(negedge clk);
    rst_ = 1'b1;
    repeat (2) @(negedge clk);
    check("t4b_busy", 32'(busy), 32'd0);
    check("t4b_tx", 32'(tx), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
